axi4_burst_writer: RTL and testbench
====================================

Name: axi4_burst_writer

Overview:
- AXI4 write initiator that drives a memory-side AXI4 slave port, such as the core's DMA port or the BRAM model.
- Takes a start command with base address and word count, consumes a valid/ready data stream, and issues INCR write bursts that never cross a 4 KB boundary.
- Used in simulation and on board to preload memory images before releasing core reset.

Parameters:
- DATA_WIDTH, 64: AXI data width in bits; must be a power of 2, at least 32.
- ADDR_WIDTH, 34: AXI address width.
- ID_WIDTH, 4: AXI ID width.
- AXI_ID, 0: constant AWID value.
- MAX_BURST, 16: maximum beats per burst; 1..256.
- COUNT_WIDTH, 24: width of the word_count field.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits are forced to 0.
- word_count  in  COUNT_WIDTH  number of DATA_WIDTH beats to write.
- s_data  in  DATA_WIDTH  input stream data.
- s_valid  in  1  input stream valid.
- s_ready  out  1  input stream ready.
- m_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4  AW payload.
- m_axi_awvalid  out  1 ; m_axi_awready  in  1.
- m_axi_wdata/wstrb/wlast  out  DATA_WIDTH/DATA_WIDTH/8/1 ; m_axi_wvalid  out  1 ; m_axi_wready  in  1.
- m_axi_bid/bresp  in  ID_WIDTH/2 ; m_axi_bvalid  in  1 ; m_axi_bready  out  1.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at command completion.
- error  out  1  sticky; set by any BRESP != OKAY; cleared on an accepted start.

Behaviour:
- Reset (aresetn low, asynchronous):
  - State goes to IDLE.
  - awvalid, wvalid, bready, s_ready, busy, done and error are all 0.
  - Address and counters are 0.
  - Reset mid-burst abandons the transfer; no further handshakes occur after release.
- Constant outputs:
  - awid = AXI_ID, awsize = log2(DATA_WIDTH/8), awburst = 2'b01, awlock = 0.
  - awcache = 4'b0011, awprot = 3'b000, awqos = 0.
  - wstrb is all ones.
- States: IDLE, CALC, AW, W, B, DONE.
- IDLE:
  - On start = 1, latch the aligned base_addr into addr and word_count into remaining, clear error, go to CALC.
  - start outside IDLE is ignored.
- CALC (one cycle):
  - If remaining == 0, go to DONE.
  - Otherwise beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) / (DATA_WIDTH/8)).
  - Register awlen = beats - 1 and awaddr = addr, then go to AW.
- AW:
  - awvalid = 1, held with stable payload until awready.
  - On handshake go to W with beat counter = 0.
- W:
  - Pass-through: wvalid = s_valid, wdata = s_data, s_ready = wready.
  - awvalid is 0 while in W; W starts only after the AW handshake.
  - wlast = 1 when the beat counter == awlen.
  - A beat transfers when s_valid & wready; the counter increments on each beat.
  - A beat with wlast transfers → go to B.
  - Gaps in s_valid simply stall the burst; there is no timeout.
- B:
  - bready = 1.
  - On bvalid, set error if bresp != 2'b00.
  - Then addr += beats * (DATA_WIDTH/8) and remaining -= beats, and go to CALC.
  - After an error response the remaining bursts still complete.
- DONE: done = 1 for exactly one cycle, then go to IDLE; busy falls in the same cycle.
- Outstanding transactions: exactly one AW/W/B sequence at a time; no write interleaving.
- s_ready is 0 in every state except W.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; there is no range check.

Test Plan:
- Short burst: start with base 0x8000_0000 and count 3; slave always ready → one AW with awlen=2, awaddr=0x8000_0000; 3 W beats with wlast on the 3rd; done pulses 2 cycles after the B handshake; error=0.
- Burst splitting: count 40 with MAX_BURST=16 → awlen sequence 15, 15, 7 at addresses base, +0x80, +0x100; memory contents match the stream.
- 4 KB boundary: base 0x8000_0FE0, count 8, 64-bit bus → first burst awlen=3 at 0x...FE0, second burst awlen=3 at 0x8000_1000.
- Zero count and stalls:
  - count 0 → done pulses with no awvalid ever asserted.
  - Random s_valid and wready/awready stalls → AW payload stays stable while awvalid is high; data order is preserved.
- Error path: the slave returns SLVERR on the 2nd of 3 bursts → error=1 at done, all 3 bursts issued; the next start clears error.
- Reset mid-operation: aresetn dropped during W beat 5 → all valids/ready go to 0 asynchronously; after release busy=0, and a new command completes correctly.

Source files
------------

// File: rtl/axi4_burst_writer.sv
// AXI4 write initiator: turns a (base address, word count) command plus a
// valid/ready data stream into INCR write bursts. Bursts never cross a 4 KB
// boundary, and only one AW/W/B sequence is in flight at a time.
//
// Handshake rule: a transfer happens on any rising clock edge where both
// valid and ready are high. A valid, once raised, holds its payload stable
// until that edge. The W channel passes through the input stream directly:
// s_valid/s_data become wvalid/wdata, and wready becomes s_ready.
module axi4_burst_writer #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 34,
  parameter int ID_WIDTH    = 4,
  parameter int AXI_ID      = 0,
  parameter int MAX_BURST   = 16,
  parameter int COUNT_WIDTH = 24
) (
  input  logic                    clock,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [COUNT_WIDTH-1:0]  word_count,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              dbg_state
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_AW   = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [COUNT_WIDTH-1:0]  remaining;
  logic [8:0]              beats;
  logic [8:0]              calc_beats;
  logic [7:0]              awlen_q;
  logic [7:0]              beat_cnt;
  logic                    error_q;
  logic [12:0]             room;
  logic [12:0]             lim;
  logic                    unused_bid;

  // BID is not checked because only one write is ever outstanding.
  assign unused_bid = ^m_axi_bid;

  // Fixed AW attributes: full-width beats, INCR, normal non-cacheable bufferable.
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = s_data;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign error         = error_q;
  assign dbg_state     = state;

  // Burst size: the smallest of the words left, MAX_BURST, and the beats that still fit before the next 4 KB page.
  always_comb begin
    room = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE_LOG2;
    if (remaining < COUNT_WIDTH'(MAX_BURST)) lim = 13'(remaining);
    else                                     lim = 13'(MAX_BURST);
    calc_beats = (lim < room) ? lim[8:0] : room[8:0];
  end

  // State register.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and handshake outputs; every channel is quiet outside its own state.
  always_comb begin
    state_nxt     = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    s_ready       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CALC;
      end
      S_CALC: state_nxt = (remaining == '0) ? S_DONE : S_AW;
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = S_W;
      end
      S_W: begin
        m_axi_wvalid = s_valid;
        s_ready      = m_axi_wready;
        m_axi_wlast  = (beat_cnt == awlen_q);
        if (s_valid && m_axi_wready && m_axi_wlast) state_nxt = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = S_CALC;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command and burst bookkeeping: address, words left, burst size, beat counter, sticky error.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      addr      <= '0;
      awaddr_q  <= '0;
      remaining <= '0;
      beats     <= '0;
      awlen_q   <= '0;
      beat_cnt  <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          addr      <= {base_addr[ADDR_WIDTH-1:SIZE_LOG2], {SIZE_LOG2{1'b0}}};
          remaining <= word_count;
          error_q   <= 1'b0;
        end
        S_CALC: if (remaining != '0) begin
          beats    <= calc_beats;
          awlen_q  <= 8'(calc_beats - 9'd1);
          awaddr_q <= addr;
        end
        S_AW: if (m_axi_awready) beat_cnt <= '0;
        S_W: if (s_valid && m_axi_wready) beat_cnt <= beat_cnt + 8'd1;
        S_B: if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) error_q <= 1'b1;
          addr      <= addr + (ADDR_WIDTH'(beats) << SIZE_LOG2);
          remaining <= remaining - COUNT_WIDTH'(beats);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_writer.sv
// Bench for axi4_burst_writer: directed commands, an AXI slave model with
// optional random stalls, and a burst/data model built from address arithmetic.
module tb_axi4_burst_writer;

  localparam int DW = 64;
  localparam int AW = 34;
  localparam int IW = 4;
  localparam int CW = 24;

  // ---------------- clock / reset ----------------
  logic            clock = 1'b0;
  logic            aresetn = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [CW-1:0]   word_count = '0;
  logic [DW-1:0]   s_data = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [IW-1:0]   awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic [3:0]      awqos;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic            busy;
  logic            done;
  logic            error;
  logic [2:0]      dbg_state;

  always #5 clock = ~clock;

  axi4_burst_writer dut (
    .clock(clock), .aresetn(aresetn), .start(start), .base_addr(base_addr),
    .word_count(word_count), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] stream_q[$];
  logic [AW-1:0] exp_aw_addr[$];
  logic [7:0]    exp_aw_len[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_evt = 0;
  int   done_cnt = 0;
  int   w_last_cnt = 0;
  int   b_done = 0;
  int   err_abs = -1;
  logic exp_err = 1'b0;
  logic stall_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: split the command into bursts limited by count, MAX_BURST=16 and the 4 KB page.
  task automatic build_model(input logic [AW-1:0] base, input int count);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int r, room, b;
    a = base & ~AW'(7);
    r = count;
    while (r > 0) begin
      room = (4096 - int'(a % 4096)) / 8;
      b = r;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(8'(b - 1));
      a = a + AW'(b * 8);
      r = r - b;
    end
    stream_q.delete();
    for (int i = 0; i < count; i++) begin
      d = {$urandom, $urandom};
      stream_q.push_back(d);
      exp_q.push_back(d);
    end
  endtask

  task automatic pin(input int idx, input logic [AW-1:0] a, input logic [7:0] len);
    check("model_pin", 64'({exp_aw_addr[idx], exp_aw_len[idx]}), 64'({a, len}));
  endtask

  // ---------------- compare process + AXI slave ----------------
  initial begin : compare_and_slave
    logic          aw_hold;
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_len;
    logic [AW-1:0] cur_addr;
    logic [7:0]    cur_len;
    int            beat;
    logic          b_hs;
    aw_hold = 1'b0; hold_addr = '0; hold_len = '0;
    cur_addr = '0; cur_len = '0; beat = 0; b_hs = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    forever begin
      @(negedge clock);
      cyc++;
      b_hs = 1'b0;
      if (!aresetn) begin
        aw_hold = 1'b0;
      end else begin
        if (start && !busy) last_evt = cyc;
        if (!busy) check("idle_quiet", 64'({awvalid, wvalid, bready, s_ready, done}), 64'd0);
        if (awvalid) begin
          check("aw_const", 64'({awid, awsize, awburst, awlock, awcache, awprot, awqos}),
                64'({4'd0, 3'd3, 2'd1, 1'b0, 4'd3, 3'd0, 4'd0}));
          check("aw_w_exclusive", 64'(wvalid), 64'd0);
          if (exp_aw_addr.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
        end
        if (wvalid) check("wstrb", 64'(wstrb), 64'hff);
        if (s_ready) check("w_passthru", 64'({wvalid, wready}), 64'({s_valid, 1'b1}));
        if (aw_hold) check("aw_stable", 64'({awvalid, awaddr, awlen}), 64'({1'b1, hold_addr, hold_len}));
        aw_hold   = awvalid && !awready;
        hold_addr = awaddr;
        hold_len  = awlen;
        if (awvalid && awready && exp_aw_addr.size() > 0) begin
          cur_addr = exp_aw_addr.pop_front();
          cur_len  = exp_aw_len.pop_front();
          check("awaddr", 64'(awaddr), 64'(cur_addr));
          check("awlen", 64'(awlen), 64'(cur_len));
          beat = 0;
        end
        if (wvalid && wready) begin
          if (exp_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
          else check("wdata", wdata, exp_q.pop_front());
          check("wlast", 64'(wlast), 64'(beat == int'(cur_len)));
          mem[cur_addr + AW'(beat * 8)] = wdata;
          beat++;
          if (beat == int'(cur_len) + 1) w_last_cnt++;
        end
        if (bvalid && bready) begin
          b_hs = 1'b1;
          b_done++;
          last_evt = cyc;
        end
        if (done) begin
          check("done_latency", 64'(cyc - last_evt), 64'd2);
          check("error_at_done", 64'(error), 64'(exp_err));
          done_cnt++;
        end
      end
      @(posedge clock);
      #1;
      awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_hs || !aresetn) begin
        bvalid = 1'b0;
      end else if (!bvalid && b_done < w_last_cnt && (!stall_en || $urandom_range(0, 1) == 1)) begin
        bvalid = 1'b1;
        bresp  = (b_done == err_abs) ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [AW-1:0] base, input int count, input int err_burst,
                         input logic stall, input int rst_after);
    int   d0, budget;
    logic hs, aborted;
    logic [AW-1:0] a_al;
    aborted  = 1'b0;
    a_al     = base & ~AW'(7);
    stall_en = stall;
    exp_err  = (err_burst >= 0);
    err_abs  = (err_burst >= 0) ? b_done + err_burst : -1;
    d0 = done_cnt;
    base_addr  = base;
    word_count = CW'(count);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("error_cleared", 64'(error), 64'd0);
    for (int i = 0; i < count && !aborted; i++) begin
      if (stall) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      end
      s_valid = 1'b1;
      s_data  = stream_q[i];
      if (i == rst_after) begin
        #2 aresetn = 1'b0;
        #1;
        check("rst_async", 64'({awvalid, wvalid, bready, s_ready, busy, done, error}), 64'd0);
        aborted = 1'b1;
      end else begin
        budget = 0;
        hs = 1'b0;
        while (!hs && budget < 500) begin
          @(negedge clock);
          hs = s_ready;
          @(posedge clock);
          #1;
          budget++;
        end
        if (!hs) begin
          check("stream_timeout", 64'd0, 64'd1);
          aborted = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
    if (rst_after >= 0) begin
      exp_q.delete();
      exp_aw_addr.delete();
      exp_aw_len.delete();
      repeat (2) @(posedge clock);
      #1 aresetn = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("busy_after_rst", 64'({busy, awvalid, wvalid, bready, dbg_state}), 64'd0);
    end else begin
      budget = 0;
      while (done_cnt == d0 && budget < 3000) begin
        @(posedge clock);
        budget++;
      end
      #1;
      check("done_count", 64'(done_cnt - d0), 64'd1);
      check("idle_after_done", 64'({busy, done}), 64'd0);
      check("queues_drained", 64'(exp_q.size() + exp_aw_addr.size()), 64'd0);
      for (int i = 0; i < count; i++)
        check("mem", mem[a_al + AW'(i * 8)], stream_q[i]);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin : main
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", 64'({awvalid, wvalid, bready, s_ready, busy, done, error, dbg_state}), 64'd0);
    aresetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle_after_release", 64'({busy, done, error}), 64'd0);

    // Short burst.
    build_model(34'h0_8000_0000, 3);
    check("model_n_short", 64'(exp_aw_addr.size()), 64'd1);
    pin(0, 34'h0_8000_0000, 8'd2);
    run_cmd(34'h0_8000_0000, 3, -1, 1'b0, -1);

    // Burst splitting at MAX_BURST.
    build_model(34'h0_8000_0000, 40);
    check("model_n_split", 64'(exp_aw_addr.size()), 64'd3);
    pin(0, 34'h0_8000_0000, 8'd15);
    pin(1, 34'h0_8000_0080, 8'd15);
    pin(2, 34'h0_8000_0100, 8'd7);
    run_cmd(34'h0_8000_0000, 40, -1, 1'b0, -1);

    // 4 KB boundary.
    build_model(34'h0_8000_0FE0, 8);
    pin(0, 34'h0_8000_0FE0, 8'd3);
    pin(1, 34'h0_8000_1000, 8'd3);
    run_cmd(34'h0_8000_0FE0, 8, -1, 1'b0, -1);

    // Zero count: done with no AW.
    build_model(34'h1_0000_0000, 0);
    run_cmd(34'h1_0000_0000, 0, -1, 1'b0, -1);

    // Unaligned base, page crossing, random stalls on every channel.
    build_model(34'h0_8000_0FC5, 20);
    pin(0, 34'h0_8000_0FC0, 8'd7);
    pin(1, 34'h0_8000_1000, 8'd11);
    run_cmd(34'h0_8000_0FC5, 20, -1, 1'b1, -1);

    // SLVERR on the second of three bursts.
    build_model(34'h0_8000_2000, 40);
    run_cmd(34'h0_8000_2000, 40, 1, 1'b0, -1);

    // Next command clears the sticky error.
    build_model(34'h0_8000_3000, 3);
    run_cmd(34'h0_8000_3000, 3, -1, 1'b0, -1);

    // Reset during the fifth beat, then a fresh command.
    build_model(34'h0_8000_4000, 10);
    run_cmd(34'h0_8000_4000, 10, -1, 1'b0, 4);
    build_model(34'h0_8000_5003, 5);
    pin(0, 34'h0_8000_5000, 8'd4);
    run_cmd(34'h0_8000_5003, 5, -1, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
